// File: rtl/psion_fb_arbiter.sv
// Frame-buffer RAM arbiter: scan reads > clear sequencer > writers A/B, one RAM slot per cycle.
// Optional macro PSION_FB_RR_EN selects round-robin between A and B (default: A has fixed priority).
module psion_fb_arbiter #(
   parameter int                ADDR_W      = 11,
   parameter int                DATA_W      = 8,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              scan_req,
   input  logic [ADDR_W-1:0] scan_addr,
   output logic              scan_valid,
   output logic [DATA_W-1:0] scan_data,
   input  logic              wa_valid,
   output logic              wa_ready,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              clear_req,
   output logic              clear_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       wr_count
);

   typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

   clr_state_t        clr_state;
   logic [ADDR_W-1:0] clear_addr;
   logic              slot_free;
   logic              grant_a;
   logic              grant_b;
   logic              rd_p1;
   logic              rd_p2;

   // The clear FSM state is visible directly as clear_busy.
   assign clear_busy = (clr_state == ST_CLEAR);
   assign slot_free  = !scan_req && !clear_busy;

   // Handshake: a write transfers in any cycle where valid && ready; ready is a function of
   // scan_req, clear_busy, both valids and the pointer only, never of the writer's addr/data.
`ifdef PSION_FB_RR_EN
   logic rr_ptr;  // 0 = A is favoured, 1 = B is favoured

   assign grant_a = slot_free && wa_valid && (!wb_valid || !rr_ptr);
   assign grant_b = slot_free && wb_valid && (!wa_valid ||  rr_ptr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= 1'b0;
      end else if (grant_a) begin
         rr_ptr <= 1'b1;
      end else if (grant_b) begin
         rr_ptr <= 1'b0;
      end
   end
`else
   assign grant_a = slot_free && wa_valid;
   assign grant_b = slot_free && wb_valid && !wa_valid;
`endif

   // Readies are forced low while reset is asserted so every output reads 0 in reset.
   assign wa_ready = grant_a && reset_n;
   assign wb_ready = grant_b && reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_state  <= ST_IDLE;
         clear_addr <= '0;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         rd_p1      <= 1'b0;
         rd_p2      <= 1'b0;
         scan_valid <= 1'b0;
         scan_data  <= '0;
         wr_count   <= '0;
      end else begin
         rd_p1      <= scan_req;
         rd_p2      <= rd_p1;
         scan_valid <= rd_p2;
         if (rd_p2) begin
            scan_data <= mem_rdata;
         end

         mem_we <= 1'b0;
         if (scan_req) begin
            mem_addr <= scan_addr;
         end else if (clear_busy) begin
            mem_addr   <= clear_addr;
            mem_we     <= 1'b1;
            mem_wdata  <= CLEAR_VALUE;
            clear_addr <= clear_addr + 1'b1;
            if (clear_addr == '1) begin
               clr_state <= ST_IDLE;
            end
         end else if (grant_a) begin
            mem_addr  <= wa_addr;
            mem_we    <= 1'b1;
            mem_wdata <= wa_data;
         end else if (grant_b) begin
            mem_addr  <= wb_addr;
            mem_we    <= 1'b1;
            mem_wdata <= wb_data;
         end

         // A clear request while already clearing is dropped.
         if (clr_state == ST_IDLE && clear_req) begin
            clr_state  <= ST_CLEAR;
            clear_addr <= '0;
         end

         if ((grant_a || grant_b) && wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/psion_fb_arbiter.md
# psion_fb_arbiter

Arbiter and sequencer for the Psion LCD frame buffer. It shares one single-port synchronous 2048x8 frame-buffer RAM between three users. The display scan-out path reads it with absolute priority. Two pixel writers, A (SPI from the Pi) and B (UART), write through valid/ready handshakes. A built-in clear sequencer fills the whole buffer with a constant. The block sits between `psion_display` and the frame-buffer RAM instance in `top`.

## Interface
- `ADDR_W`, 11, frame-buffer address width (2048 bytes)
- `DATA_W`, 8, frame-buffer byte width (two 4-bit pixels)
- `CLEAR_VALUE`, 8'h00, byte written by the clear sequencer
---
- `clk` in 1: system clock (24 MHz)
- `reset_n` in 1: asynchronous, active-low reset
- `scan_req` in 1: scan read request, one cycle per byte
- `scan_addr` in ADDR_W: scan read address
- `scan_valid` out 1: one-cycle strobe, `scan_data` is valid
- `scan_data` out DATA_W: read byte
- `wa_valid`, `wb_valid` in 1: writer has a write pending
- `wa_ready`, `wb_ready` out 1: write accepted this cycle
- `wa_addr`, `wb_addr` in ADDR_W: write address
- `wa_data`, `wb_data` in DATA_W: write byte
- `clear_req` in 1: pulse that starts a full-buffer clear
- `clear_busy` out 1: clear in progress
- `mem_addr` out ADDR_W: registered RAM address
- `mem_we` out 1: registered RAM write enable
- `mem_wdata` out DATA_W: registered RAM write data
- `mem_rdata` in DATA_W: RAM read data, valid one cycle after the address
- `wr_count` out 16: saturating count of accepted A/B writes

## Operation
- The arbiter grants exactly one RAM slot per cycle.
- Priority order is: scan > clear > writers A/B > idle.
- **Scan slot** (`scan_req`=1): the request is registered onto `mem_addr` with `mem_we`=0. Scan requests are fully pipelined and may arrive every cycle.
- **Clear slot** (`clear_busy`=1 and `scan_req`=0): write `CLEAR_VALUE` to `clear_addr`, then `clear_addr` increments by 1.
- **Writer slot** (`scan_req`=0, `clear_busy`=0, at least one valid): grant one writer.
  - `wX_ready` is combinational from `scan_req`, `clear_busy`, both valids and the round-robin pointer.
  - Ready never depends on the same writer's `addr`/`data`.
  - A transfer occurs when `valid && ready`. The next cycle carries `mem_we`=1 with that writer's address and data.
  - `wr_count` increments on each transfer and saturates at 16'hFFFF.
  - A writer must hold `valid`, `addr` and `data` stable until it is accepted.
- **Idle slot**: `mem_we`=0, `mem_addr` holds its previous value.
- **Clear sequencer** has two states, IDLE and CLEAR.
  - IDLE→CLEAR on `clear_req` while IDLE; `clear_addr` is set to 0.
  - `clear_req` during CLEAR is ignored.
  - CLEAR→IDLE in the cycle after the write to address 2047 is issued. Exactly 2048 writes are issued.
  - Writers see ready=0 throughout CLEAR.
- Read/write ordering: a scan read issued one cycle before a write to the same address returns the old byte. There is no forwarding.
- On `reset_n`=0, asynchronously:
  - all outputs go to 0 (`mem_addr`, `mem_we`, `mem_wdata`, `scan_valid`, `scan_data`, `clear_busy`, `wr_count`, both readys);
  - the round-robin pointer goes to A; the clear state goes to IDLE; the scan pipeline is flushed.
- Reset in the middle of a clear aborts it. The buffer contents are then undefined and no resume occurs.

## Timing
- Scan latency is 3 cycles:
  - `scan_req` at cycle N;
  - `mem_addr` valid at N+1;
  - `mem_rdata` at N+2;
  - `scan_valid`=1 and `scan_data` at N+3.
- Write latency: accepted at N, `mem_we`=1 at N+1.
- A clear of 2048 bytes with no scan traffic takes 2048 cycles. Each scan request adds 1 cycle.
- Writers are never starved by scan: the display issues at most 1 scan request per 8 clocks.

## Configuration
- `PSION_FB_RR_EN` defined:
  - round-robin between A and B;
  - the pointer flips to the other writer after each grant;
  - when only one writer is valid, that writer is granted regardless of the pointer.
- `PSION_FB_RR_EN` undefined:
  - fixed priority, A always beats B;
  - the pointer logic is removed.

## Test plan
- Reset: hold `reset_n`=0 mid-activity → every output is 0. Release, then `scan_req` at addr 0x005 with RAM[5]=0xA7 → `scan_valid` pulses exactly 3 cycles later with data 0xA7.
- Priority: `scan_req`, `wa_valid` and `wb_valid` all high in one cycle → `wa_ready`=`wb_ready`=0. In the next cycle with `scan_req`=0, exactly one ready is high.
- Round robin (with `PSION_FB_RR_EN`): A and B both valid for 4 cycles → grants alternate A, B, A, B and `wr_count`=4. Without the macro the grants are A, A, A, A.
- Clear: pulse `clear_req` with `scan_req` every 8 cycles:
  - exactly 2048 `mem_we` cycles with data 0x00 and addresses 0..2047 in order;
  - `wa_ready` stays 0 throughout;
  - a second `clear_req` mid-clear is ignored.
- Reset mid-clear at `clear_addr`=0x300 → `clear_busy` drops asynchronously. After release, `wa_valid` is accepted immediately.
- Saturation: preload `wr_count` to 0xFFFE and perform 3 writes → the count reads 0xFFFF.
